comp_sar_ctrl: RTL and testbench

Successive-approximation controller that runs the opposite direction of the DAC/comparator test block. It drives a WIDTH-bit code into the on-chip DAC, reads back the differential comparator decision (comp_p/comp_m), and resolves one bit per step, MSB first, to a digital result. It sits inside the tile wrapper between the dedicated inputs and outputs, next to the DAC/comparator macro. The comparator outputs are asynchronous to clk, so they are synchronised inside this block.

---
 rtl/comp_sar_pkg.sv | 26 ++
 rtl/comp_sync2.sv | 23 ++
 rtl/comp_sar_ctrl.sv | 170 +++++++++++++++++
 tb/tb_comp_sar_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/comp_sar_pkg.sv
// rtl/comp_sar_pkg.sv - shared state, synchroniser depth and comparator-pair decode for comp_sar_ctrl
package comp_sar_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   localparam int SYNC_STAGES = 2;

   // Comparator pair as {comp_p, comp_m}; the equal codes mean the macro gave no valid decision.
   typedef enum logic [1:0] {
      CMP_BAD_00 = 2'b00,
      CMP_LOW    = 2'b01,
      CMP_HIGH   = 2'b10,
      CMP_BAD_11 = 2'b11
   } cmp_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/comp_sync2.sv
// rtl/comp_sync2.sv - two-flop synchroniser for one asynchronous comparator output
module comp_sync2
   import comp_sar_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/comp_sar_ctrl.sv
// rtl/comp_sar_ctrl.sv - MSB-first SAR controller driving the DAC; COMP_MAJORITY_EN enables 3-sample voting
module comp_sar_ctrl
   import comp_sar_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             comp_p,
   input  logic             comp_m,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             error
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(SETTLE);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] trial_q, trial_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             p_s, m_s;
   logic             vp, vm, resolve;
   logic [WIDTH-1:0] bit_mask, trial_res;

`ifdef COMP_MAJORITY_EN
   logic [1:0] scnt_q, scnt_d;
   logic [1:0] vp_q, vp_d;
   logic [1:0] vm_q, vm_d;
`endif

   comp_sync2 u_sync_p (.clk(clk), .rst_n(rst_n), .d_i(comp_p), .q_o(p_s));
   comp_sync2 u_sync_m (.clk(clk), .rst_n(rst_n), .d_i(comp_m), .q_o(m_s));

   always_comb begin
      state_d   = state_q;
      trial_d   = trial_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      dac_d     = dac_q;
      result_d  = result_q;
      done_d    = 1'b0;
      error_d   = error_q;
      vp        = p_s;
      vm        = m_s;
      resolve   = 1'b0;
      bit_mask  = WIDTH'(1) << idx_q;
      trial_res = trial_q;
`ifdef COMP_MAJORITY_EN
      scnt_d    = scnt_q;
      vp_d      = vp_q;
      vm_d      = vm_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               trial_d = '0;
               idx_d   = IW'(WIDTH - 1);
               error_d = 1'b0;
               state_d = S_SET;
            end
         end
         S_SET: begin
            trial_d = trial_q | bit_mask;
            dac_d   = trial_q | bit_mask;
            cnt_d   = CW'(SETTLE - 1);
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SAMPLE: begin
`ifdef COMP_MAJORITY_EN
            // Collect two samples, vote on the third together with the live one.
            if (scnt_q != 2'd2) begin
               vp_d   = {vp_q[0], p_s};
               vm_d   = {vm_q[0], m_s};
               scnt_d = scnt_q + 2'd1;
            end else begin
               vp      = maj3(vp_q[1], vp_q[0], p_s);
               vm      = maj3(vm_q[1], vm_q[0], m_s);
               scnt_d  = 2'd0;
               resolve = 1'b1;
            end
`else
            resolve = 1'b1;
`endif
            if (resolve) begin
               case (cmp_e'({vp, vm}))
                  CMP_HIGH: trial_res = trial_q;
                  CMP_LOW:  trial_res = trial_q & ~bit_mask;
                  default: begin
                     trial_res = trial_q & ~bit_mask;
                     error_d   = 1'b1;
                  end
               endcase
               trial_d = trial_res;
               if (idx_q == '0) begin
                  dac_d    = trial_res;
                  result_d = trial_res;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = S_SET;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         trial_q  <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         dac_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef COMP_MAJORITY_EN
         scnt_q   <= 2'd0;
         vp_q     <= 2'd0;
         vm_q     <= 2'd0;
`endif
      end else begin
         state_q  <= state_d;
         trial_q  <= trial_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         dac_q    <= dac_d;
         result_q <= result_d;
         done_q   <= done_d;
         error_q  <= error_d;
`ifdef COMP_MAJORITY_EN
         scnt_q   <= scnt_d;
         vp_q     <= vp_d;
         vm_q     <= vm_d;
`endif
      end
   end

   assign dac_code = dac_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign result   = result_q;
   assign error    = error_q;

endmodule

// File: tb/tb_comp_sar_ctrl.sv
// tb/tb_comp_sar_ctrl.sv - self-checking bench for comp_sar_ctrl with an ideal comparator model
module tb_comp_sar_ctrl;

   localparam int W  = 8;
   localparam int ST = 2;
`ifdef COMP_MAJORITY_EN
   localparam int NS = 3;
`else
   localparam int NS = 1;
`endif
   localparam int P   = ST + 1 + NS;
   localparam int LAT = W * P + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [7:0]   vin;
   logic         force_both;
   logic         glitch;
   logic         ideal;
   logic         comp_p, comp_m;
   logic [W-1:0] dac_code, result;
   logic         busy, done, error;

   assign ideal  = (vin >= dac_code);
   assign comp_p = force_both ? 1'b1 : (glitch ? ~ideal : ideal);
   assign comp_m = force_both ? 1'b1 : ~ideal;

   comp_sar_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .comp_p(comp_p), .comp_m(comp_m),
      .dac_code(dac_code), .busy(busy), .done(done), .result(result), .error(error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Spec-level SAR: for each bit MSB-first, try it and keep it if vin >= trial.
   logic [W-1:0] m_trial [W];
   logic [W-1:0] m_res;
   logic         m_err;

   task automatic model(input logic [7:0] v, input int fbit);
      logic [W-1:0] t;
      t     = '0;
      m_err = 1'b0;
      for (int b = W - 1; b >= 0; b--) begin
         t[b] = 1'b1;
         m_trial[W-1-b] = t;
         if (b == fbit) begin
            t[b]  = 1'b0;
            m_err = 1'b1;
         end else if (!(v >= t)) begin
            t[b] = 1'b0;
         end
      end
      m_res = t;
   endtask

   int           d_cyc, d_cnt, busy_bad;
   logic [W-1:0] got_trial [W];

   task automatic run_conv(input logic [7:0] v, input int fbit, input bit glit, input int restart_at);
      vin        = v;
      force_both = 1'b0;
      glitch     = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      d_cyc    = -1;
      d_cnt    = 0;
      busy_bad = 0;
      for (int n = 1; n <= LAT + 4; n++) begin
         int  k, pos;
         bit  in_win;
         k      = (n >= 2) ? (n - 2) / P : 0;
         pos    = (n >= 2) ? (n - 2) % P : 0;
         in_win = (n >= 2) && (pos < NS) && (k < W);
         force_both = (fbit >= 0) && in_win && (k == W - 1 - fbit);
         glitch     = glit && in_win && (pos == 0);
         start      = (n == restart_at);
         if (n >= 2 && pos == 0 && k < W) got_trial[k] = dac_code;
         if (done) begin
            d_cnt++;
            if (d_cyc < 0) d_cyc = n;
         end
         if (n <= LAT && !busy) busy_bad++;
         if (n > LAT && busy) busy_bad++;
         @(posedge clk);
         #1;
      end
      force_both = 1'b0;
      glitch     = 1'b0;
      start      = 1'b0;
   endtask

   task automatic check_conv(input string tag, input logic [7:0] v, input int fbit,
                             input logic [7:0] exp_res, input logic exp_err);
      check({tag, "/done_cycle"}, d_cyc, LAT);
      check({tag, "/done_count"}, d_cnt, 1);
      check({tag, "/busy"}, busy_bad, 0);
      check({tag, "/result"}, result, exp_res);
      check({tag, "/error"}, error, exp_err);
      check({tag, "/dac_final"}, dac_code, exp_res);
      model(v, fbit);
      for (int k = 0; k < W; k++) check({tag, $sformatf("/trial%0d", k)}, got_trial[k], m_trial[k]);
   endtask

   typedef struct {
      logic [7:0] vin;
      int         fbit;
      logic [7:0] exp_res;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] a5_seq [8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      int v, fb, cnt;
      rst_n      = 1'b0;
      start      = 1'b0;
      vin        = 8'h00;
      force_both = 1'b0;
      glitch     = 1'b0;

      vecs.push_back('{8'hA5, -1, 8'hA5, 1'b0});
      vecs.push_back('{8'h00, -1, 8'h00, 1'b0});
      vecs.push_back('{8'hFF, -1, 8'hFF, 1'b0});
      vecs.push_back('{8'hFF,  5, 8'hDF, 1'b1});
      vecs.push_back('{8'h3C, -1, 8'h3C, 1'b0});
      for (int i = 0; i < 6; i++) begin
         v  = $urandom_range(0, 255);
         fb = (i >= 4) ? int'($urandom_range(0, W - 1)) : -1;
         model(v[7:0], fb);
         vecs.push_back('{v[7:0], fb, m_res, m_err});
      end

      repeat (3) @(posedge clk);
      #1;
      check("reset/dac_code", dac_code, 0);
      check("reset/busy", busy, 0);
      check("reset/done", done, 0);
      check("reset/result", result, 0);
      check("reset/error", error, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_conv(vecs[i].vin, vecs[i].fbit, 1'b0, 0);
         check_conv($sformatf("vec%0d", i), vecs[i].vin, vecs[i].fbit, vecs[i].exp_res, vecs[i].exp_err);
      end

      a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      run_conv(8'hA5, -1, 1'b0, 0);
      for (int k = 0; k < W; k++) check($sformatf("a5_seq%0d", k), got_trial[k], a5_seq[k]);

      run_conv(8'h5A, -1, 1'b0, 10);
      check_conv("restart_ignored", 8'h5A, -1, 8'h5A, 1'b0);

      vin = 8'hA5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check("abort/busy", busy, 0);
      check("abort/done", done, 0);
      check("abort/dac_code", dac_code, 0);
      check("abort/result", result, 0);
      check("abort/error", error, 0);
      cnt = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
      check("abort/no_done", cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_conv(8'hA5, -1, 1'b0, 0);
      check_conv("after_abort", 8'hA5, -1, 8'hA5, 1'b0);

`ifdef COMP_MAJORITY_EN
      run_conv(8'h3C, -1, 1'b1, 0);
      check_conv("majority_glitch", 8'h3C, -1, 8'h3C, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
